// File: rtl/riscv_addsub_issue_stage.sv
// riscv_addsub_issue_stage
// Issue / operand-latch stage feeding the add/sub execute unit.
// It takes decoded ADD/SUB/SLT/SLTU ops and picks s2 from rs2 or the immediate.
// Writeback forwarding is applied when an op is captured and for as long as it is held.
// Storage is a main register that drives ex_* plus one skid register.
// in_rdy comes only from registered occupancy, so it has no combinational path from ex_rdy.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   flush            drop every buffered entry
//   in_*             decode side: valid/ready, op, operand indices/values, imm, rd
//   wb_*             writeback bus used for forwarding
//   ex_*             execute side: valid/ready, operands, exec op, flags, rd
module riscv_addsub_issue_stage #(
   parameter int CPU_WIDTH = 32,
   parameter int REG_IDX_W = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_vld,
   output logic                 in_rdy,
   input  logic [1:0]           in_op,
   input  logic                 in_use_imm,
   input  logic [CPU_WIDTH-1:0] in_imm,
   input  logic [REG_IDX_W-1:0] in_rs1_idx,
   input  logic [REG_IDX_W-1:0] in_rs2_idx,
   input  logic [CPU_WIDTH-1:0] in_rs1_val,
   input  logic [CPU_WIDTH-1:0] in_rs2_val,
   input  logic [REG_IDX_W-1:0] in_rd_idx,
   input  logic                 wb_vld,
   input  logic [REG_IDX_W-1:0] wb_rd_idx,
   input  logic [CPU_WIDTH-1:0] wb_data,
   output logic                 ex_vld,
   input  logic                 ex_rdy,
   output logic [CPU_WIDTH-1:0] ex_s1,
   output logic [CPU_WIDTH-1:0] ex_s2,
   output logic [1:0]           ex_op,
   output logic                 ex_unsigned,
   output logic                 ex_is_cmp,
   output logic [REG_IDX_W-1:0] ex_rd_idx
);

   // One buffered op. The source indices and use_imm stay with the entry,
   // so writebacks that arrive while it waits can still be forwarded into it.
   typedef struct packed {
      logic [CPU_WIDTH-1:0] s1;
      logic [CPU_WIDTH-1:0] s2;
      logic [1:0]           op;
      logic                 uns;
      logic                 cmp;
      logic [REG_IDX_W-1:0] rd;
      logic [REG_IDX_W-1:0] rs1_idx;
      logic [REG_IDX_W-1:0] rs2_idx;
      logic                 use_imm;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t state_reg;
   entry_t main_reg, skid_reg;
   entry_t main_upd, skid_upd, cap;
   logic   ex_vld_reg, in_rdy_reg;
   logic   accept, drain;

   // Apply the current writeback to a held entry. x0 never matches, and an
   // immediate s2 is never overwritten.
   function automatic entry_t held_fwd(entry_t e, logic v,
                                       logic [REG_IDX_W-1:0] idx,
                                       logic [CPU_WIDTH-1:0] d);
      entry_t r;
      r = e;
      if (v && (idx != '0)) begin
         if (e.rs1_idx == idx)
            r.s1 = d;
         if (!e.use_imm && (e.rs2_idx == idx))
            r.s2 = d;
      end
      return r;
   endfunction

   assign accept = in_vld & in_rdy_reg;
   assign drain  = ex_vld_reg & ex_rdy;

   always_comb begin
      main_upd = held_fwd(main_reg, wb_vld, wb_rd_idx, wb_data);
      skid_upd = held_fwd(skid_reg, wb_vld, wb_rd_idx, wb_data);
   end

   // Capture-side operand select with forwarding from the same-cycle writeback
   always_comb begin
      cap         = '0;
      cap.rs1_idx = in_rs1_idx;
      cap.rs2_idx = in_rs2_idx;
      cap.use_imm = in_use_imm;
      cap.rd      = in_rd_idx;
      cap.op      = (in_op == 2'd0) ? 2'b01 : 2'b10;
      cap.uns     = (in_op == 2'd3);
      cap.cmp     = in_op[1];
      cap.s1      = (wb_vld && (in_rs1_idx != '0) && (wb_rd_idx == in_rs1_idx))
                    ? wb_data : in_rs1_val;
      if (in_use_imm)
         cap.s2 = in_imm;
      else if (wb_vld && (in_rs2_idx != '0) && (wb_rd_idx == in_rs2_idx))
         cap.s2 = wb_data;
      else
         cap.s2 = in_rs2_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= EMPTY;
         ex_vld_reg <= 1'b0;
         in_rdy_reg <= 1'b1;
         main_reg   <= '0;
         skid_reg   <= '0;
      end else begin
         // Held entries track writebacks every cycle unless reloaded below
         main_reg <= main_upd;
         skid_reg <= skid_upd;
         if (flush) begin
            // Operand contents may go stale here; only validity matters
            state_reg  <= EMPTY;
            ex_vld_reg <= 1'b0;
            in_rdy_reg <= 1'b1;
         end else begin
            case (state_reg)
               EMPTY: begin
                  if (accept) begin
                     main_reg   <= cap;
                     state_reg  <= ONE;
                     ex_vld_reg <= 1'b1;
                  end
               end
               ONE: begin
                  if (accept && drain) begin
                     main_reg <= cap;
                  end else if (accept) begin
                     skid_reg   <= cap;
                     state_reg  <= TWO;
                     in_rdy_reg <= 1'b0;
                  end else if (drain) begin
                     state_reg  <= EMPTY;
                     ex_vld_reg <= 1'b0;
                  end
               end
               TWO: begin
                  if (drain) begin
                     // Skid moves up, carrying this cycle's forwarded data
                     main_reg   <= skid_upd;
                     state_reg  <= ONE;
                     in_rdy_reg <= 1'b1;
                  end
               end
               default: begin
                  state_reg  <= EMPTY;
                  ex_vld_reg <= 1'b0;
                  in_rdy_reg <= 1'b1;
               end
            endcase
         end
      end
   end

   assign in_rdy      = in_rdy_reg;
   assign ex_vld      = ex_vld_reg;
   assign ex_s1       = main_reg.s1;
   assign ex_s2       = main_reg.s2;
   assign ex_op       = main_reg.op;
   assign ex_unsigned = main_reg.uns;
   assign ex_is_cmp   = main_reg.cmp;
   assign ex_rd_idx   = main_reg.rd;

endmodule

// File: doc/riscv_addsub_issue_stage.md
Name: riscv_addsub_issue_stage

Overview:
Issue/operand-latch stage directly upstream of the add/sub execute unit. Accepts decoded ALU ops (ADD, SUB, SLT, SLTU) from decode and selects s2 from rs2 or the immediate. Applies writeback forwarding to the operands and presents registered s1/s2/op to the execute interface. Uses a valid/ready handshake with a 2-entry skid buffer, so decode stalls never create a combinational ready path.

Parameters:
CPU_WIDTH, 32, operand/result width (32 for RV32, 64 for RV64)
REG_IDX_W, 5, register index width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
flush  in  1  kill all buffered entries (branch mispredict/trap)
in_vld  in  1  decode has an op
in_rdy  out  1  stage can accept
in_op  in  2  0=ADD 1=SUB 2=SLT 3=SLTU
in_use_imm  in  1  s2 taken from in_imm
in_imm  in  CPU_WIDTH  sign-extended immediate
in_rs1_idx  in  REG_IDX_W  rs1 index
in_rs2_idx  in  REG_IDX_W  rs2 index
in_rs1_val  in  CPU_WIDTH  regfile rs1 value
in_rs2_val  in  CPU_WIDTH  regfile rs2 value
in_rd_idx  in  REG_IDX_W  destination index
wb_vld  in  1  writeback writing this cycle
wb_rd_idx  in  REG_IDX_W  writeback destination
wb_data  in  CPU_WIDTH  writeback data
ex_vld  out  1  execute operands valid
ex_rdy  in  1  execute consumes
ex_s1  out  CPU_WIDTH  operand 1
ex_s2  out  CPU_WIDTH  operand 2
ex_op  out  2  exec op: 2'b01 add, 2'b10 sub/compare
ex_unsigned  out  1  1 for SLTU, else 0
ex_is_cmp  out  1  1 for SLT/SLTU (downstream takes less-than result)
ex_rd_idx  out  REG_IDX_W  destination index

Behaviour:
- Reset: ex_vld=0, in_rdy=1, ex_s1/ex_s2/ex_op/ex_unsigned/ex_is_cmp/ex_rd_idx=0, both entries invalid.
- Storage is a main register driving the ex_* outputs plus one skid register. FSM by occupancy: EMPTY, ONE (main valid), TWO (main+skid valid).
- in_rdy = (state != TWO), registered; no combinational path from ex_rdy.
- Accept = in_vld & in_rdy. Drain = ex_vld & ex_rdy.
- EMPTY: accept -> ONE (load main).
- ONE: accept & drain -> ONE (main reloaded). Accept only -> TWO (load skid). Drain only -> EMPTY.
- TWO: drain -> ONE (skid moves to main). No drain -> TWO. No accept is possible in TWO.
- Latency: an op accepted at edge N is on ex_* after edge N when the stage was EMPTY or draining; it never appears in the same cycle it is accepted.
- Op map: ADD -> ex_op=01. SUB/SLT/SLTU -> ex_op=10. ex_unsigned = (in_op==3). ex_is_cmp = in_op[1].
- Operand select: s1 = rs1 value. s2 = in_use_imm ? in_imm : rs2 value.
- Forwarding at capture: if wb_vld and wb_rd_idx == rsX_idx and rsX_idx != 0, use wb_data instead of the regfile value.
- Forwarding while held: each entry keeps its rs1/rs2 indices and use_imm flag. A writeback matching a held, nonzero index updates that operand in the same edge. Immediate s2 is never overwritten.
- x0 is never forwarded. An x0 operand stays the regfile value as captured (0).
- Skid->main transfer in the same cycle as a matching writeback: the transferred value includes the forwarded data.
- flush: the next state is EMPTY and ex_vld=0. Flush overrides accept and drain in the same cycle. in_rdy=1 the cycle after. Operand registers may hold stale data but ex_vld must be 0.
- rst asserted mid-operation: same effect as flush, plus all output fields cleared to 0.
- All arithmetic is width-exact; no extension inside this block.

Test Plan:
- Back-to-back ADD with ex_rdy=1: rs1=5, rs2=7, ADD -> next cycle ex_vld=1, ex_s1=5, ex_s2=7, ex_op=01, ex_unsigned=0. Throughput 1/cycle, in_rdy stays 1.
- Backpressure: ex_rdy=0, issue 3 ops -> two accepted, in_rdy=0 after the 2nd. Release ex_rdy -> ops emerge in order with no loss or duplication, then in_rdy returns to 1.
- Capture forwarding: rs1_idx=3, regfile val 0x11, wb_vld=1, wb_rd_idx=3, wb_data=0xAA at accept -> ex_s1=0xAA. Same with rs1_idx=0 and wb_rd_idx=0 -> ex_s1=0.
- Held forwarding: op stalled in main (ex_rdy=0) with rs2_idx=9; writeback x9=0x1234 -> ex_s2 becomes 0x1234 next cycle. With use_imm=1, imm=0xFFFFFFF0 -> ex_s2 stays 0xFFFFFFF0.
- Op map: SLTU with rs1=1, imm=2 -> ex_op=10, ex_unsigned=1, ex_is_cmp=1, ex_s2=2. SLT -> ex_op=10, ex_unsigned=0, ex_is_cmp=1.
- Flush in TWO state together with in_vld=1 -> next cycle ex_vld=0, in_rdy=1, and the op presented during flush is not issued. Reset pulse mid-stream gives the same result with all ex_* fields = 0.
